// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt capture stage that feeds
// the 8-to-3 priority encoder.
package irq_pkg;

    localparam int IRQ_N   = 8;
    localparam int IRQ_IDW = 3;

    typedef logic [IRQ_N-1:0]   irq_vec_t;
    typedef logic [IRQ_IDW-1:0] irq_id_t;

    // Every line enabled out of reset.
    localparam irq_vec_t IRQ_MASK_RST = '1;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// Single-bit two-flop synchronizer with a rising-edge detector. The delayed
// copy resets to 0, so a line held high through reset yields one edge.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync_q,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // Two-flop metastability chain plus one-cycle delay for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its predecessor; blocking here would collapse the chain.
            sync1  <= din;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign sync_q = sync2;
    assign rise   = sync2 & ~sync_d;

endmodule : irq_sync_edge

// File: rtl/irq_capture.sv
// Captures asynchronous request lines as sticky pending bits, masks them
// for the downstream priority encoder, retires the serviced line on a clear
// handshake and flags events that land on an already-pending line.
module irq_capture
    import irq_pkg::*;
#(
    parameter int             N         = IRQ_N,
    parameter int             IDW       = IRQ_IDW,
    parameter bit             EDGE_MODE = 1'b1,
    parameter logic [N-1:0]   MASK_RST  = {N{1'b1}}
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   irq_in,
    input  logic           mask_we,
    input  logic [N-1:0]   mask_wdata,
    output logic [N-1:0]   mask_q,
    input  logic           clr_valid,
    input  logic [IDW-1:0] clr_id,
    input  logic           ovf_clr,
    output logic [N-1:0]   pending,
    output logic           pending_any,
    output logic [N-1:0]   overflow
);

    logic [N-1:0] sync_lvl;
    logic [N-1:0] sync_rise;
    logic [N-1:0] ev;
    logic [N-1:0] clr_hit;
    logic [N-1:0] raw_pending;
    logic [N-1:0] pend_next;
    logic [N-1:0] ovf_next;

    // Per-line synchronizer, event select and clear decode. Indices at or
    // beyond N never match any line, so out-of-range clears are ignored.
    for (genvar i = 0; i < N; i++) begin : g_line
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (irq_in[i]),
            .sync_q (sync_lvl[i]),
            .rise   (sync_rise[i])
        );

        assign ev[i]      = EDGE_MODE ? sync_rise[i] : sync_lvl[i];
        assign clr_hit[i] = clr_valid && (clr_id == IDW'(i));
    end

    // Next pending/overflow state: a new event always wins over a clear so
    // nothing is lost; an event on a still-pending line becomes overflow.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pend_next = ev | (raw_pending & ~clr_hit);
        ovf_next  = '0;
        if (EDGE_MODE) begin
            ovf_next = ovf_clr ? '0 : overflow;
            ovf_next = ovf_next | (ev & raw_pending & ~clr_hit);
        end
    end

    // Capture state and mask register; masking never gates capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of control flops, not a memory array,
            // so all of them are reset to give a defined state after rst_n.
            raw_pending <= '0;
            overflow    <= '0;
            mask_q      <= MASK_RST;
        end else begin
            raw_pending <= pend_next;
            overflow    <= ovf_next;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign pending     = raw_pending & mask_q;
    assign pending_any = |pending;

endmodule : irq_capture
